// File: rtl/smem_pkg.sv
// Shared constants for the read store: query status codes,
// load line width and the query liveness rule.
package smem_pkg;

   localparam int CL = 512;

   localparam logic [5:0] F_init  = 6'h00;
   localparam logic [5:0] F_run   = 6'h01;
   localparam logic [5:0] F_break = 6'h02;
   localparam logic [5:0] DONE    = 6'h03;
   localparam logic [5:0] BCK_INI = 6'h04;
   localparam logic [5:0] BCK_RUN = 6'h05;
   localparam logic [5:0] BCK_END = 6'h06;
   localparam logic [5:0] BUBBLE  = 6'h30;

   function automatic logic q_live(input logic [5:0] s);
      return !(s == BUBBLE || s == F_break || s == BCK_END);
   endfunction

endpackage

// File: rtl/query_extract.sv
// One query channel: quarter, word, then byte select over three
// registered stages, with a valid bit travelling alongside.
module query_extract
   import smem_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic [5:0]   status,
   input  logic [6:0]   position,
   input  logic         read_ok,
   input  logic [511:0] line1,
   input  logic [511:0] line2,
   output logic [7:0]   q_data,
   output logic         q_valid
);

   logic         v1, v2, v3;
   logic [255:0] quarter;
   logic [4:0]   pos1;
   logic [63:0]  word;
   logic [2:0]   pos2;
   logic [7:0]   byte_q;
   logic [511:0] half_src;

   always_comb begin
      half_src = line1;
      if (position[6]) half_src = line2;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         quarter <= '0;
         pos1    <= '0;
         word    <= '0;
         pos2    <= '0;
         byte_q  <= '0;
      end else begin
         v1      <= q_live(status) && read_ok;
         quarter <= position[5] ? half_src[511:256]
                                : half_src[255:0];
         pos1    <= position[4:0];
         v2      <= v1;
         word    <= quarter[{pos1[4:3], 6'd0} +: 64];
         pos2    <= pos1[2:0];
         v3      <= v2;
         byte_q  <= word[{pos2, 3'd0} +: 8];
      end
   end

   assign q_valid = v3;
   assign q_data  = v3 ? byte_q : 8'hFF;

endmodule

// File: rtl/read_store_mp.sv
// Batch read store: loads 4 lines per read, dispenses reads in
// order and serves byte queries on independent ports.
module read_store_mp #(
   parameter  int MAX_READ   = 256,
   parameter  int NUM_QPORTS = 2,
   parameter  int CL         = smem_pkg::CL,
   localparam int RNW        = $clog2(MAX_READ)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic [CL-1:0]             load_data,
   input  logic [RNW:0]              batch_size,
   output logic                      load_done,
   input  logic                      batch_clear,
   output logic                      new_read_valid,
   input  logic                      new_read_ready,
   output logic [RNW-1:0]            new_read_num,
   output logic [63:0]               new_ik_x0,
   output logic [63:0]               new_ik_x1,
   output logic [63:0]               new_ik_x2,
   output logic [63:0]               new_ik_info,
   output logic [6:0]                new_forward_i,
   output logic [6:0]                new_min_intv,
   output logic                      batch_drained,
   input  logic [NUM_QPORTS*6-1:0]   q_status,
   input  logic [NUM_QPORTS*7-1:0]   q_position,
   input  logic [NUM_QPORTS*RNW-1:0] q_read_num,
   output logic [NUM_QPORTS*8-1:0]   q_data,
   output logic [NUM_QPORTS-1:0]     q_valid,
   output logic [63:0]               primary,
   output logic [63:0]               L2_0,
   output logic [63:0]               L2_1,
   output logic [63:0]               L2_2,
   output logic [63:0]               L2_3
);

   localparam logic [RNW:0]   ONE   = (RNW+1)'(1);
   localparam logic [RNW+1:0] P0_AD = (RNW+2)'(2);
   localparam logic [RNW+1:0] K0_AD = (RNW+2)'(3);

   logic [CL-1:0]  mem [MAX_READ*4];
   logic [RNW:0]   read_count;
   logic [RNW:0]   rd_ptr;
   logic [1:0]     line_cnt;
   logic           beat;
   logic           take;
   logic [RNW+1:0] waddr;
   logic [RNW+1:0] pa;
   logic [RNW+1:0] ia;

   assign load_ready = !load_done && (read_count < batch_size);
   assign beat       = load_valid && load_ready;
   assign waddr      = {read_count[RNW-1:0], line_cnt};

   assign new_read_valid = load_done && (rd_ptr < read_count);
   assign take           = new_read_valid && new_read_ready;
   assign batch_drained  = load_done && (rd_ptr == read_count);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         read_count <= '0;
         line_cnt   <= '0;
         rd_ptr     <= '0;
         load_done  <= 1'b0;
      end else if (batch_clear) begin
         read_count <= '0;
         line_cnt   <= '0;
         rd_ptr     <= '0;
         load_done  <= 1'b0;
      end else begin
         if (beat) begin
            line_cnt <= line_cnt + 2'd1;
            if (line_cnt == 2'd3)
               read_count <= read_count + ONE;
         end
         // batch_size 0 must never complete
         if (read_count == batch_size && batch_size != '0)
            load_done <= 1'b1;
         if (take) rd_ptr <= rd_ptr + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (beat && !batch_clear) mem[waddr] <= load_data;
   end

   assign pa = {rd_ptr[RNW-1:0], 2'd2};
   assign ia = {rd_ptr[RNW-1:0], 2'd3};

   assign new_read_num  = rd_ptr[RNW-1:0];
   assign new_ik_x0     = new_read_valid ? mem[ia][63:0]    : '1;
   assign new_ik_x1     = new_read_valid ? mem[ia][127:64]  : '1;
   assign new_ik_x2     = new_read_valid ? mem[ia][191:128] : '1;
   assign new_ik_info   = new_read_valid ? mem[ia][255:192] : '1;
   assign new_forward_i = new_read_valid ? mem[pa][6:0]     : '1;
   assign new_min_intv  = new_read_valid ? mem[pa][70:64]   : '1;

   assign primary = mem[P0_AD][191:128];
   assign L2_0    = mem[K0_AD][319:256];
   assign L2_1    = mem[K0_AD][383:320];
   assign L2_2    = mem[K0_AD][447:384];
   assign L2_3    = mem[K0_AD][511:448];

   for (genvar p = 0; p < NUM_QPORTS; p++) begin : g_q
      logic [RNW-1:0] rn;
      logic [RNW+1:0] a1;
      logic [RNW+1:0] a2;
      assign rn = q_read_num[p*RNW +: RNW];
      assign a1 = {rn, 2'd0};
      assign a2 = {rn, 2'd1};
      query_extract u_qx (
         .clk      (clk),
         .reset_n  (reset_n),
         .status   (q_status[p*6 +: 6]),
         .position (q_position[p*7 +: 7]),
         .read_ok  ({1'b0, rn} < read_count),
         .line1    (mem[a1][511:0]),
         .line2    (mem[a2][511:0]),
         .q_data   (q_data[p*8 +: 8]),
         .q_valid  (q_valid[p])
      );
   end

endmodule

// File: doc/read_store_mp.md
READ_STORE_MP -- requirements
Module: read_store_mp

Interface
REQ-001 SHALL have parameter MAX_READ, default 256, maximum reads per batch (power of two).
REQ-002 SHALL have parameter NUM_QPORTS, default 2, number of independent query channels.
REQ-003 SHALL have parameter CL, default 512, load line width in bits; RNW = clog2(MAX_READ).
REQ-004 SHALL have port clk, input, 1, the only clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports load_valid, input, 1, and load_ready, output, 1, the load handshake.
REQ-007 SHALL have port load_data, input, CL, the load line.
REQ-008 SHALL have port batch_size, input, RNW+1, the read count, sampled while loading.
REQ-009 SHALL have ports load_done, output, 1, and batch_clear, input, 1, a one-cycle restart pulse.
REQ-010 SHALL have ports new_read_valid, output, 1, and new_read_ready, input, 1, the dispense handshake.
REQ-011 SHALL have port new_read_num, output, RNW, the dispensed read number.
REQ-012 SHALL have ports new_ik_x0, new_ik_x1, new_ik_x2 and new_ik_info, output, 64 each, ik fields.
REQ-013 SHALL have ports new_forward_i and new_min_intv, output, 7 each, the read parameters.
REQ-014 SHALL have port batch_drained, output, 1, high when every loaded read has been dispensed.
REQ-015 SHALL have ports q_status, input, NUM_QPORTS*6; q_position, input, NUM_QPORTS*7; and q_read_num, input, NUM_QPORTS*RNW.
REQ-016 SHALL have ports q_data, output, NUM_QPORTS*8, and q_valid, output, NUM_QPORTS.
REQ-017 SHALL have ports primary and L2_0, L2_1, L2_2, L2_3, output, 64 each.

Function
REQ-018 SHALL store each read as 4 lines in load order: read_1, read_2, param, ik; a 2-bit line counter wraps 3->0 and advances the read counter.
REQ-019 SHALL accept a line when load_valid&&load_ready; load_ready = !load_done && read_count < batch_size.
REQ-020 SHALL register load_done high in the cycle after read_count == batch_size && batch_size != 0; batch_size 0 never completes.
REQ-021 SHALL drive new_read_valid = load_done && rd_ptr < read_count, combinationally; rd_ptr increments on valid&&ready only.
REQ-022 SHALL take new_ik_x0/x1/x2/info from ik[63:0]/[127:64]/[191:128]/[255:192], new_forward_i from param[6:0] and new_min_intv from param[70:64]; all are all-ones while new_read_valid is low; new_read_num = rd_ptr.
REQ-023 SHALL take primary from param line of read 0 [191:128] and L2_0..3 from ik line of read 0 [319:256]..[511:448].
REQ-024 SHALL assert batch_drained = load_done && rd_ptr == read_count.
REQ-025 SHALL on batch_clear zero read_count, the line counter, rd_ptr and load_done next cycle; batch_clear overrides a simultaneous load beat or dispense.
REQ-026 SHALL give each query port an independent 3-stage pipeline, latency 3 cycles, one query per cycle per port.
REQ-027 SHALL treat a query as valid when status is not BUBBLE (6'h30), F_break (6'h2) or BCK_END (6'h6).
REQ-028 SHALL stage 1: select a 256-bit quarter by position[6:5] (00 read_1 low, 01 read_1 high, 10 read_2 low, 11 read_2 high).
REQ-029 SHALL stage 2: select a 64-bit word by position[4:3]; stage 3: select a byte by position[2:0], byte 0 = bits [7:0].
REQ-030 SHALL propagate a valid bit with each query; q_valid is high exactly 3 cycles after a valid query, and q_data = 8'hFF when q_valid is low.
REQ-031 SHALL treat a query with q_read_num >= read_count as invalid, giving q_valid 0 and 8'hFF.
REQ-032 SHALL allow queries while loading continues; a query to a fully loaded read returns stored data.

Reset
REQ-033 SHALL on reset_n low asynchronously clear all counters, pointers, load_done, query pipelines and q_valid, and set q_data to all-ones; RAM contents are not reset.
REQ-034 SHALL return to the empty, not-done state after reset asserted mid-load or mid-dispense, dropping in-flight queries.

Structure
REQ-035 SHALL place status codes (F_init, F_run, F_break, BCK_INI, BCK_RUN, BCK_END, BUBBLE, DONE) and CL in shared package smem_pkg.
REQ-036 SHALL implement the per-port pipeline as sub-module query_extract, instantiated NUM_QPORTS times.

Verification
REQ-037 SHALL cover: batch_size 2 with 8 beats -> load_done high 1 cycle after beat 8, load_ready low after it, and a 9th beat ignored.
REQ-038 SHALL cover: new_read_ready held 1 -> new_read_num 0 then 1, then new_read_valid 0, batch_drained 1 and outputs all-ones.
REQ-039 SHALL cover: read_1 byte k = k, query position 7'd37 status F_run -> q_data 8'd37 with q_valid 3 cycles later; position 7'd64 returns read_2 byte 0.
REQ-040 SHALL cover: port 0 status BUBBLE and port 1 BCK_RUN in the same cycle -> port 0 gives q_valid 0/8'hFF and port 1 gives valid data.
REQ-041 SHALL cover: batch_clear while new_read_valid is high -> load_done 0 and rd_ptr 0, after which a second batch of 1 loads and dispenses read 0.
REQ-042 SHALL cover: reset_n pulsed low mid-pipeline -> q_valid 0 immediately, with no stale output after release.
